// File: rtl/vga_timing_module_if.sv
// vga_timing_module_if -- video timing bundle from the timing generator to
// the pixel pipeline.
//
// There is no handshake on this bundle: the generator is free-running and the
// consumer cannot stall it. Every signal is valid on every clock after reset,
// and the consumer simply samples it on the rising edge of the pixel clock.
interface vga_timing_module_if;
  logic        HSYNC_Sig;        // active-low horizontal sync
  logic        VSYNC_Sig;        // active-low vertical sync
  logic        Ready_Sig;        // high inside the visible window
  logic [10:0] Column_Addr_Sig;  // visible column, 0 outside the window
  logic [10:0] Row_Addr_Sig;     // visible row, 0 outside the window
  logic        Frame_Start_Sig;  // one-clock pulse at the frame origin

  modport master (
    output HSYNC_Sig,
    output VSYNC_Sig,
    output Ready_Sig,
    output Column_Addr_Sig,
    output Row_Addr_Sig,
    output Frame_Start_Sig
  );

  modport slave (
    input HSYNC_Sig,
    input VSYNC_Sig,
    input Ready_Sig,
    input Column_Addr_Sig,
    input Row_Addr_Sig,
    input Frame_Start_Sig
  );
endinterface

// File: rtl/vga_timing_module.sv
// vga_timing_module -- VGA horizontal/vertical timing generator.
//
// A line is laid out as sync, back porch, active, front porch (same order for
// the frame in lines). hcnt/vcnt walk the raster; every output is registered
// from the current (hcnt, vcnt), so outputs lag the counters by one clock.
//
// Build option: define VGA_SYNC_ALIGN_EN to add one extra register on
// HSYNC_Sig and VSYNC_Sig (two clocks total), so sync lines up with a
// downstream pixel stage that registers the address once. Ready_Sig, the
// addresses and Frame_Start_Sig are not affected by the option.
module vga_timing_module #(
  parameter logic [10:0] H_SYNC   = 11'd128,
  parameter logic [10:0] H_BACK   = 11'd88,
  parameter logic [10:0] H_ACTIVE = 11'd800,
  parameter logic [10:0] H_FRONT  = 11'd40,
  parameter logic [10:0] V_SYNC   = 11'd4,
  parameter logic [10:0] V_BACK   = 11'd23,
  parameter logic [10:0] V_ACTIVE = 11'd600,
  parameter logic [10:0] V_FRONT  = 11'd1
) (
  input  logic                CLK,
  input  logic                RST,
  vga_timing_module_if.master vga
);

  // Totals are required to fit in 11 bits (at most 2047).
  localparam logic [10:0] H_TOTAL     = H_SYNC + H_BACK + H_ACTIVE + H_FRONT;
  localparam logic [10:0] H_VIS_START = H_SYNC + H_BACK;
  localparam logic [10:0] H_VIS_END   = H_VIS_START + H_ACTIVE;
  localparam logic [10:0] V_TOTAL     = V_SYNC + V_BACK + V_ACTIVE + V_FRONT;
  localparam logic [10:0] V_VIS_START = V_SYNC + V_BACK;
  localparam logic [10:0] V_VIS_END   = V_VIS_START + V_ACTIVE;

  logic [10:0] hcnt;
  logic [10:0] vcnt;
  logic        h_last;
  logic        v_last;

  // Decoded next values of the output registers.
  logic        hsync_d;
  logic        vsync_d;
  logic        ready_d;
  logic [10:0] col_d;
  logic [10:0] row_d;
  logic        frame_start_d;

  // Output registers.
  logic        hsync_q;
  logic        vsync_q;
  logic        ready_q;
  logic [10:0] col_q;
  logic [10:0] row_q;
  logic        frame_start_q;

  assign h_last = (hcnt == (H_TOTAL - 11'd1));
  assign v_last = (vcnt == (V_TOTAL - 11'd1));

  // Raster counters: hcnt every clock, vcnt only when the line wraps.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      hcnt <= 11'd0;
      vcnt <= 11'd0;
    end else begin
      if (h_last) begin
        hcnt <= 11'd0;
        if (v_last) begin
          vcnt <= 11'd0;
        end else begin
          vcnt <= vcnt + 11'd1;
        end
      end else begin
        hcnt <= hcnt + 11'd1;
      end
    end
  end

  // Decode sync, visible window and addresses from the current counters.
  always_comb begin
    hsync_d       = 1'b1;
    vsync_d       = 1'b1;
    ready_d       = 1'b0;
    col_d         = 11'd0;
    row_d         = 11'd0;
    frame_start_d = 1'b0;

    if (hcnt < H_SYNC) begin
      hsync_d = 1'b0;
    end
    if (vcnt < V_SYNC) begin
      vsync_d = 1'b0;
    end

    if ((hcnt >= H_VIS_START) && (hcnt < H_VIS_END) &&
        (vcnt >= V_VIS_START) && (vcnt < V_VIS_END)) begin
      ready_d = 1'b1;
      col_d   = hcnt - H_VIS_START;
      row_d   = vcnt - V_VIS_START;
    end

    if ((hcnt == 11'd0) && (vcnt == 11'd0)) begin
      frame_start_d = 1'b1;
    end
  end

  // Register every output; reset drives all of them to 0, including sync.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      hsync_q       <= 1'b0;
      vsync_q       <= 1'b0;
      ready_q       <= 1'b0;
      col_q         <= 11'd0;
      row_q         <= 11'd0;
      frame_start_q <= 1'b0;
    end else begin
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      ready_q       <= ready_d;
      col_q         <= col_d;
      row_q         <= row_d;
      frame_start_q <= frame_start_d;
    end
  end

`ifdef VGA_SYNC_ALIGN_EN
  logic hsync_q2;
  logic vsync_q2;

  // Extra sync stage so sync matches a pixel pipeline one register deep.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      hsync_q2 <= 1'b0;
      vsync_q2 <= 1'b0;
    end else begin
      hsync_q2 <= hsync_q;
      vsync_q2 <= vsync_q;
    end
  end

  assign vga.HSYNC_Sig = hsync_q2;
  assign vga.VSYNC_Sig = vsync_q2;
`else
  assign vga.HSYNC_Sig = hsync_q;
  assign vga.VSYNC_Sig = vsync_q;
`endif

  assign vga.Ready_Sig       = ready_q;
  assign vga.Column_Addr_Sig = col_q;
  assign vga.Row_Addr_Sig    = row_q;
  assign vga.Frame_Start_Sig = frame_start_q;

endmodule

// File: tb/tb_vga_timing_module.sv
// tb_vga_timing_module -- bench for vga_timing_module.
// dut_a uses the default 800x600 timing; dut_b uses a tiny raster so whole
// frames are cheap, and is checked cycle by cycle against a reference model.
module tb_vga_timing_module;

  // Small raster for dut_b: H_TOTAL = 17, V_TOTAL = 10, frame = 170 clocks.
  localparam int BH_SYNC = 4;
  localparam int BH_BACK = 3;
  localparam int BH_ACT  = 8;
  localparam int BH_FRT  = 2;
  localparam int BV_SYNC = 2;
  localparam int BV_BACK = 2;
  localparam int BV_ACT  = 5;
  localparam int BV_FRT  = 1;
  localparam int BH_TOT  = BH_SYNC + BH_BACK + BH_ACT + BH_FRT;
  localparam int BV_TOT  = BV_SYNC + BV_BACK + BV_ACT + BV_FRT;

`ifdef VGA_SYNC_ALIGN_EN
  localparam int SD = 1;
`else
  localparam int SD = 0;
`endif

  logic clk = 1'b0;
  logic rst_a = 1'b1;
  logic rst_b = 1'b1;

  int n_tests = 0;
  int n_fail  = 0;
  int ea = 0;
  int eb = 0;

  logic [25:0] exp_q[$];

  vga_timing_module_if if_a();
  vga_timing_module_if if_b();

  vga_timing_module dut_a (
    .CLK (clk),
    .RST (rst_a),
    .vga (if_a)
  );

  vga_timing_module #(
    .H_SYNC  (11'(BH_SYNC)),
    .H_BACK  (11'(BH_BACK)),
    .H_ACTIVE(11'(BH_ACT)),
    .H_FRONT (11'(BH_FRT)),
    .V_SYNC  (11'(BV_SYNC)),
    .V_BACK  (11'(BV_BACK)),
    .V_ACTIVE(11'(BV_ACT)),
    .V_FRONT (11'(BV_FRT))
  ) dut_b (
    .CLK (clk),
    .RST (rst_b),
    .vga (if_b)
  );

  // Clock / reset
  always #5 clk = ~clk;

  // Driver / check tasks
  task automatic step();
    @(posedge clk);
    ea++;
    eb++;
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_tests++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  // Expected outputs of the small raster for counter position (h, v).
  function automatic logic [25:0] model_out(input int h, input int v);
    logic        hs, vs, rdy, fs;
    logic [10:0] col, row;
    hs  = !(h < BH_SYNC);
    vs  = !(v < BV_SYNC);
    rdy = (h >= BH_SYNC + BH_BACK) && (h < BH_SYNC + BH_BACK + BH_ACT) &&
          (v >= BV_SYNC + BV_BACK) && (v < BV_SYNC + BV_BACK + BV_ACT);
    col = rdy ? 11'(h - (BH_SYNC + BH_BACK)) : 11'd0;
    row = rdy ? 11'(v - (BV_SYNC + BV_BACK)) : 11'd0;
    fs  = (h == 0) && (v == 0);
    return {hs, vs, rdy, col, row, fs};
  endfunction

  // Scoreboard producer: each clock dut_b advances, push its expected output.
  initial begin : sb_model
    int mh, mv;
    logic ph, pv;
    logic [25:0] e;
    mh = 0; mv = 0; ph = 1'b0; pv = 1'b0;
    forever begin
      @(posedge clk or posedge rst_b);
      if (rst_b) begin
        mh = 0; mv = 0; ph = 1'b0; pv = 1'b0;
        exp_q.delete();
      end else begin
        e = model_out(mh, mv);
        if (SD == 1) begin
          logic nh, nv;
          nh = e[25]; nv = e[24];
          e[25] = ph; e[24] = pv;
          ph = nh; pv = nv;
        end
        exp_q.push_back(e);
        if (mh == BH_TOT - 1) begin
          mh = 0;
          mv = (mv == BV_TOT - 1) ? 0 : mv + 1;
        end else begin
          mh = mh + 1;
        end
      end
    end
  end

  // Scoreboard consumer: compare dut_b away from the active edge.
  initial begin : sb_check
    logic [25:0] e;
    logic [25:0] o;
    forever begin
      @(negedge clk);
      if (!rst_b && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        o = {if_b.HSYNC_Sig, if_b.VSYNC_Sig, if_b.Ready_Sig,
             if_b.Column_Addr_Sig, if_b.Row_Addr_Sig, if_b.Frame_Start_Sig};
        chk($sformatf("sb_small_e%0d", eb), 32'(o), 32'(e));
      end
    end
  end

  // Directed sequence
  initial begin : main
    int   falls[3];
    int   rises[3];
    int   nf, nr, fs_cnt, vs_low, n, guard;
    logic prev_hs;
    nf = 0; nr = 0; fs_cnt = 0; vs_low = 0;
    prev_hs = 1'b0;

    rst_a = 1'b1;
    rst_b = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_a_outputs", 32'({if_a.HSYNC_Sig, if_a.VSYNC_Sig, if_a.Ready_Sig,
        if_a.Column_Addr_Sig, if_a.Row_Addr_Sig, if_a.Frame_Start_Sig}), 32'd0);
    chk("reset_b_outputs", 32'({if_b.HSYNC_Sig, if_b.VSYNC_Sig, if_b.Ready_Sig,
        if_b.Column_Addr_Sig, if_b.Row_Addr_Sig, if_b.Frame_Start_Sig}), 32'd0);

    @(negedge clk);
    rst_a = 1'b0;
    rst_b = 1'b0;
    ea = 0;
    eb = 0;

    // Two small frames plus three default lines.
    for (int i = 0; i < 3400; i++) begin
      step();
      if (eb == 1 || eb == 171 || eb == 341)
        chk($sformatf("frame_start_e%0d", eb), 32'(if_b.Frame_Start_Sig), 32'd1);
      if (eb <= 341) fs_cnt += int'(if_b.Frame_Start_Sig);
      if (eb >= 2 && eb <= 171 && !if_b.VSYNC_Sig) vs_low++;
      if (eb == 151) begin
        chk("last_px_ready", 32'(if_b.Ready_Sig), 32'd1);
        chk("last_px_col", 32'(if_b.Column_Addr_Sig), 32'(BH_ACT - 1));
        chk("last_px_row", 32'(if_b.Row_Addr_Sig), 32'(BV_ACT - 1));
      end
      if (eb == 152) begin
        chk("after_last_ready", 32'(if_b.Ready_Sig), 32'd0);
        chk("after_last_addr", 32'({if_b.Column_Addr_Sig, if_b.Row_Addr_Sig}), 32'd0);
      end
      if (prev_hs && !if_a.HSYNC_Sig && nf < 3) begin
        falls[nf] = ea;
        nf++;
      end
      if (!prev_hs && if_a.HSYNC_Sig && nf > 0 && nr < 3) begin
        rises[nr] = ea;
        nr++;
      end
      prev_hs = if_a.HSYNC_Sig;
    end
    chk("frame_start_count", 32'(fs_cnt), 32'd3);
    chk("vsync_low_clocks", 32'(vs_low), 32'(BV_SYNC * BH_TOT));
    chk("hsync_fall_count", 32'(nf), 32'd3);
    chk("hsync_rise_count", 32'(nr), 32'd3);
    chk("hsync_first_fall", 32'(falls[0]), 32'(1057 + SD));
    chk("hsync_period", 32'(falls[1] - falls[0]), 32'd1056);
    chk("hsync_width_0", 32'(rises[0] - falls[0]), 32'd128);
    chk("hsync_width_1", 32'(rises[1] - falls[1]), 32'd128);

    // Asynchronous mid-frame reset of the small DUT.
    #2;
    rst_b = 1'b1;
    #1;
    chk("async_rst_b_outputs", 32'({if_b.HSYNC_Sig, if_b.VSYNC_Sig, if_b.Ready_Sig,
        if_b.Column_Addr_Sig, if_b.Row_Addr_Sig, if_b.Frame_Start_Sig}), 32'd0);
    step();
    step();
    @(negedge clk);
    rst_b = 1'b0;
    eb = 0;

    // First visible pixel of the default raster.
    guard = 0;
    while (!if_a.Ready_Sig && guard < 40000) begin
      step();
      guard++;
    end
    chk("first_ready_edge", 32'(ea), 32'd28729);
    chk("first_ready_col", 32'(if_a.Column_Addr_Sig), 32'd0);
    chk("first_ready_row", 32'(if_a.Row_Addr_Sig), 32'd0);

    n = 0;
    while (if_a.Ready_Sig && n < 2000) begin n++; step(); end
    chk("ready_run_line0", 32'(n), 32'd800);
    n = 0;
    while (!if_a.Ready_Sig && n < 2000) begin n++; step(); end
    chk("ready_gap", 32'(n), 32'd256);
    chk("line1_first_row", 32'(if_a.Row_Addr_Sig), 32'd1);
    n = 0;
    while (if_a.Ready_Sig && n < 2000) begin n++; step(); end
    chk("ready_run_line1", 32'(n), 32'd800);

    // Asynchronous mid-line reset of the default DUT, then timing repeats.
    repeat (400) step();
    #2;
    rst_a = 1'b1;
    #1;
    chk("async_rst_a_outputs", 32'({if_a.HSYNC_Sig, if_a.VSYNC_Sig, if_a.Ready_Sig,
        if_a.Column_Addr_Sig, if_a.Row_Addr_Sig, if_a.Frame_Start_Sig}), 32'd0);
    step();
    step();
    chk("held_rst_a_outputs", 32'({if_a.HSYNC_Sig, if_a.VSYNC_Sig, if_a.Ready_Sig,
        if_a.Column_Addr_Sig, if_a.Row_Addr_Sig, if_a.Frame_Start_Sig}), 32'd0);
    @(negedge clk);
    rst_a = 1'b0;
    ea = 0;
    step();
    chk("restart_frame_start", 32'(if_a.Frame_Start_Sig), 32'd1);
    guard = 0;
    while (!if_a.Ready_Sig && guard < 40000) begin
      step();
      guard++;
    end
    chk("rerun_first_ready_edge", 32'(ea), 32'd28729);
    chk("rerun_first_ready_addr", 32'({if_a.Column_Addr_Sig, if_a.Row_Addr_Sig}), 32'd0);

    // Final report
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/vga_timing_module.md
VGA_TIMING_MODULE -- requirements
Module: vga_timing_module

Interface
REQ-001 SHALL have parameter H_SYNC, default 11'd128, meaning horizontal sync pulse width in clocks.
REQ-002 SHALL have parameter H_BACK, default 11'd88, meaning horizontal back porch in clocks.
REQ-003 SHALL have parameter H_ACTIVE, default 11'd800, meaning visible pixels per line.
REQ-004 SHALL have parameter H_FRONT, default 11'd40, meaning horizontal front porch in clocks.
REQ-005 SHALL have parameter V_SYNC, default 11'd4, meaning vertical sync width in lines.
REQ-006 SHALL have parameter V_BACK, default 11'd23, meaning vertical back porch in lines.
REQ-007 SHALL have parameter V_ACTIVE, default 11'd600, meaning visible lines per frame.
REQ-008 SHALL have parameter V_FRONT, default 11'd1, meaning vertical front porch in lines.
REQ-009 SHALL have port CLK, input, 1 bit, pixel clock (40 MHz for the defaults); the block uses one clock only.
REQ-010 SHALL have port RST, input, 1 bit, asynchronous active-high reset.
REQ-011 SHALL have port HSYNC_Sig, output, 1 bit, active-low horizontal sync.
REQ-012 SHALL have port VSYNC_Sig, output, 1 bit, active-low vertical sync.
REQ-013 SHALL have port Ready_Sig, output, 1 bit, high inside the visible window.
REQ-014 SHALL have port Column_Addr_Sig, output, 11 bits, visible column, 0..H_ACTIVE-1.
REQ-015 SHALL have port Row_Addr_Sig, output, 11 bits, visible row, 0..V_ACTIVE-1.
REQ-016 SHALL have port Frame_Start_Sig, output, 1 bit, one-clock pulse at frame origin.

Function
REQ-017 SHALL hold 11-bit counters hcnt and vcnt, where H_TOTAL = H_SYNC+H_BACK+H_ACTIVE+H_FRONT, V_TOTAL is the analogous vertical sum, and both totals are at most 2047.
REQ-018 SHALL increment hcnt every clock and wrap it from H_TOTAL-1 to 0.
REQ-019 SHALL increment vcnt only on the hcnt wrap, and wrap vcnt from V_TOTAL-1 to 0 on that same edge.
REQ-020 SHALL register every output from the current (hcnt,vcnt), giving one clock of latency from counter to output.
REQ-021 SHALL drive HSYNC_Sig low exactly when hcnt < H_SYNC, and VSYNC_Sig low exactly when vcnt < V_SYNC.
REQ-022 SHALL drive Ready_Sig high exactly when H_SYNC+H_BACK <= hcnt < H_SYNC+H_BACK+H_ACTIVE and V_SYNC+V_BACK <= vcnt < V_SYNC+V_BACK+V_ACTIVE.
REQ-023 SHALL drive Column_Addr_Sig = hcnt-(H_SYNC+H_BACK) and Row_Addr_Sig = vcnt-(V_SYNC+V_BACK) when Ready_Sig is high, and 0 on both when it is low.
REQ-024 SHALL assert Frame_Start_Sig for exactly one clock per frame, decoded from hcnt=0 and vcnt=0.
REQ-025 SHALL produce no Ready_Sig and no out-of-range address during porches or sync; the last visible pixel is (H_ACTIVE-1, V_ACTIVE-1) and its next clock has Ready_Sig low.

Reset
REQ-026 SHALL, while RST is high and regardless of CLK, force hcnt=0, vcnt=0, HSYNC_Sig=0, VSYNC_Sig=0, Ready_Sig=0, both addresses 0 and Frame_Start_Sig=0.
REQ-027 SHALL, when RST is asserted mid-frame, abandon the frame immediately and restart timing from (0,0) on release; the first output update occurs on the first rising edge after release.

Configuration
REQ-028 SHALL, when macro VGA_SYNC_ALIGN_EN is defined, delay HSYNC_Sig and VSYNC_Sig by one extra register (two clocks of latency total, reset value 0), aligning sync with the downstream pixel stage, which registers its address once.
REQ-029 SHALL, when VGA_SYNC_ALIGN_EN is undefined, give all outputs identical one-clock latency; Ready_Sig, the address outputs and Frame_Start_Sig are unaffected by the macro in both builds.

Verification
REQ-030 SHALL cover: defaults, release RST -> Ready_Sig first high after rising edge 28729, with Column_Addr_Sig=0 and Row_Addr_Sig=0.
REQ-031 SHALL cover: free run for 2 lines -> HSYNC_Sig low for exactly 128 clocks every 1056 clocks; Ready_Sig high for exactly 800 consecutive clocks per visible line.
REQ-032 SHALL cover: run 2 frames -> Frame_Start_Sig pulses at edge 663169, then every 663168 clocks, 1 clock wide; VSYNC_Sig low for 4*1056 clocks per frame.
REQ-033 SHALL cover: last visible pixel -> Column_Addr_Sig=799 and Row_Addr_Sig=599 with Ready_Sig=1; on the next clock Ready_Sig=0 and both addresses 0.
REQ-034 SHALL cover: assert RST asynchronously mid-line (between edges) -> all outputs 0 immediately; after release the timing from REQ-030 repeats exactly.
REQ-035 SHALL cover: build with VGA_SYNC_ALIGN_EN -> the HSYNC_Sig falling edge lags the non-macro build by exactly 1 clock, and Ready_Sig timing is identical in both builds.
